// File: rtl/pmem_arbiter_if.sv
// rtl/pmem_arbiter_if.sv - requester and pmem bus bundle for pmem_arbiter
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  i_error;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  d_error;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  logic                  pmem_error;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
    input  pmem_rdata, pmem_resp, pmem_error,
    output i_rdata, i_resp, i_error, d_rdata, d_resp, d_error,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
    output pmem_rdata, pmem_resp, pmem_error,
    input  i_rdata, i_resp, i_error, d_rdata, d_resp, d_error,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin arbiter of I-cache and D-cache misses onto one pmem port
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  pmem_arbiter_if.master bus
);
  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-OFFSET){1'b1}}, {OFFSET{1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;     // 0 = I, 1 = D
  logic                  owner_q, owner_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_err_q, i_err_d;
  logic                  d_err_q, d_err_d;

  logic                  i_req, d_req, grant_d;
  logic [ADDR_WIDTH-1:0] sel_addr;

  assign i_req    = bus.i_read;
  assign d_req    = bus.d_read | bus.d_write;
  assign grant_d  = d_req & (~i_req | ~last_q);
  assign sel_addr = grant_d ? bus.d_address : bus.i_address;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b0;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_err_d   = i_err_q;
    d_err_d   = d_err_q;
    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          state_d = BUSY;
          owner_d = grant_d;
          // A simultaneous read and write from the D side is treated as a writeback.
          wr_d    = grant_d & bus.d_write;
          addr_d  = sel_addr & LINE_MASK;
          wdata_d = bus.d_wdata;
          last_d  = grant_d;
        end
      end
      BUSY: begin
        if (bus.pmem_resp) begin
          state_d = RESP;
          if (owner_q) begin
            d_rdata_d = bus.pmem_rdata;
            d_err_d   = bus.pmem_error;
          end else begin
            i_rdata_d = bus.pmem_rdata;
            i_err_d   = bus.pmem_error;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commands come straight from state so an asynchronous reset drops them at once.
  always_comb begin
    bus.pmem_read    = (state_q == BUSY) & ~wr_q;
    bus.pmem_write   = (state_q == BUSY) & wr_q;
    bus.pmem_address = addr_q;
    bus.pmem_wdata   = wdata_q;
    bus.i_resp       = (state_q == RESP) & ~owner_q;
    bus.d_resp       = (state_q == RESP) & owner_q;
    bus.i_error      = (state_q == RESP) & ~owner_q & i_err_q;
    bus.d_error      = (state_q == RESP) & owner_q & d_err_q;
    bus.i_rdata      = i_rdata_q;
    bus.d_rdata      = d_rdata_q;
  end
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - directed self-checking bench for pmem_arbiter
module tb_pmem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_l(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [LW-1:0] wd1, wd2, a5, rd_d1, rd_i1, rd_d2, rd_i2, rd_d3, rd_e, rd_f;

  initial begin
    wd1   = {4{64'h0123_4567_89AB_CDEF}};
    wd2   = {8{32'hCAFE_F00D}};
    a5    = {32{8'hA5}};
    rd_d1 = {8{32'hD0D0_0001}};
    rd_i1 = {8{32'h1111_0001}};
    rd_d2 = {8{32'hD0D0_0002}};
    rd_i2 = {8{32'h1111_0002}};
    rd_d3 = {8{32'hD0D0_0003}};
    rd_e  = {8{32'hEEEE_0000}};
    rd_f  = {8{32'hF00F_F00F}};

    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0; bus.pmem_error = 1'b0;

    // Reset state
    repeat (2) tick;
    chk("rst_pmem_read", bus.pmem_read, 1'b0);
    chk("rst_pmem_write", bus.pmem_write, 1'b0);
    chk_a("rst_pmem_address", bus.pmem_address, 32'h0);
    chk_l("rst_pmem_wdata", bus.pmem_wdata, '0);
    chk("rst_i_resp", bus.i_resp, 1'b0);
    chk("rst_d_resp", bus.d_resp, 1'b0);
    chk("rst_i_error", bus.i_error, 1'b0);
    chk("rst_d_error", bus.d_error, 1'b0);
    chk_l("rst_i_rdata", bus.i_rdata, '0);
    chk_l("rst_d_rdata", bus.d_rdata, '0);
    rst_n = 1'b1;
    tick;

    // Single I read
    bus.i_read = 1'b1; bus.i_address = 32'h0000_1234;
    tick;
    chk("t1_pmem_read", bus.pmem_read, 1'b1);
    chk("t1_pmem_write", bus.pmem_write, 1'b0);
    chk_a("t1_pmem_address", bus.pmem_address, 32'h0000_1220);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = a5;
    tick;
    bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
    chk("t1_i_resp", bus.i_resp, 1'b1);
    chk_l("t1_i_rdata", bus.i_rdata, a5);
    chk("t1_i_error", bus.i_error, 1'b0);
    chk("t1_d_resp", bus.d_resp, 1'b0);
    chk("t1_pmem_read_off", bus.pmem_read, 1'b0);
    tick;
    chk("t1_i_resp_once", bus.i_resp, 1'b0);
    chk_l("t1_i_rdata_hold", bus.i_rdata, a5);

    // D writeback with a 10-cycle stall; inputs change but latched values must hold
    bus.d_write = 1'b1; bus.d_address = 32'h8000_0040; bus.d_wdata = wd1; bus.pmem_rdata = '0;
    tick;
    chk("t2_pmem_write", bus.pmem_write, 1'b1);
    chk("t2_pmem_read", bus.pmem_read, 1'b0);
    chk_a("t2_pmem_address", bus.pmem_address, 32'h8000_0040);
    chk_l("t2_pmem_wdata", bus.pmem_wdata, wd1);
    bus.d_address = 32'h0; bus.d_wdata = '0;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("t2_stall_write", bus.pmem_write, 1'b1);
      chk("t2_stall_read", bus.pmem_read, 1'b0);
      chk_a("t2_stall_address", bus.pmem_address, 32'h8000_0040);
      chk_l("t2_stall_wdata", bus.pmem_wdata, wd1);
      chk("t2_stall_d_resp", bus.d_resp, 1'b0);
    end
    bus.pmem_resp = 1'b1;
    tick;
    bus.pmem_resp = 1'b0; bus.d_write = 1'b0;
    chk("t2_d_resp", bus.d_resp, 1'b1);
    chk("t2_i_resp", bus.i_resp, 1'b0);
    chk("t2_pmem_write_off", bus.pmem_write, 1'b0);
    chk("t2_pmem_read_off", bus.pmem_read, 1'b0);
    tick;
    chk("t2_d_resp_once", bus.d_resp, 1'b0);

    // Simultaneous pair from reset: D first, then I after one idle cycle
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    bus.i_read = 1'b1; bus.i_address = 32'h0000_0100;
    bus.d_read = 1'b1; bus.d_address = 32'h2000_0204;
    tick;
    chk("t3_d_pmem_read", bus.pmem_read, 1'b1);
    chk_a("t3_d_address", bus.pmem_address, 32'h2000_0200);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = rd_d1;
    tick;
    bus.pmem_resp = 1'b0; bus.d_read = 1'b0;
    chk("t3_d_resp", bus.d_resp, 1'b1);
    chk_l("t3_d_rdata", bus.d_rdata, rd_d1);
    chk("t3_i_resp_quiet", bus.i_resp, 1'b0);
    tick;
    chk("t3_idle_gap", bus.pmem_read, 1'b0);
    chk("t3_d_resp_once", bus.d_resp, 1'b0);
    tick;
    chk("t3_i_pmem_read", bus.pmem_read, 1'b1);
    chk_a("t3_i_address", bus.pmem_address, 32'h0000_0100);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = rd_i1;
    tick;
    bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
    chk("t3_i_resp", bus.i_resp, 1'b1);
    chk_l("t3_i_rdata", bus.i_rdata, rd_i1);
    chk("t3_d_resp_quiet", bus.d_resp, 1'b0);
    tick;

    // Lone D read moves the pointer to D, so the next pair goes to I
    bus.d_read = 1'b1; bus.d_address = 32'h0000_0300;
    tick;
    chk_a("t3_d2_address", bus.pmem_address, 32'h0000_0300);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = rd_d2;
    tick;
    bus.pmem_resp = 1'b0; bus.d_read = 1'b0;
    chk("t3_d2_resp", bus.d_resp, 1'b1);
    chk_l("t3_d2_rdata", bus.d_rdata, rd_d2);
    tick;
    bus.i_read = 1'b1; bus.i_address = 32'h0000_0400;
    bus.d_read = 1'b1; bus.d_address = 32'h0000_0500;
    tick;
    chk("t3_p2_i_read", bus.pmem_read, 1'b1);
    chk_a("t3_p2_i_address", bus.pmem_address, 32'h0000_0400);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = rd_i2;
    tick;
    bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
    chk("t3_p2_i_resp", bus.i_resp, 1'b1);
    chk_l("t3_p2_i_rdata", bus.i_rdata, rd_i2);
    chk("t3_p2_d_quiet", bus.d_resp, 1'b0);
    tick;
    tick;
    chk("t3_p2_d_read", bus.pmem_read, 1'b1);
    chk_a("t3_p2_d_address", bus.pmem_address, 32'h0000_0500);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = rd_d3;
    tick;
    bus.pmem_resp = 1'b0; bus.d_read = 1'b0;
    chk("t3_p2_d_resp", bus.d_resp, 1'b1);
    chk_l("t3_p2_d_rdata", bus.d_rdata, rd_d3);
    tick;

    // d_read and d_write together: writeback
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 32'h0000_0600; bus.d_wdata = wd2;
    tick;
    chk("t4_pmem_write", bus.pmem_write, 1'b1);
    chk("t4_pmem_read", bus.pmem_read, 1'b0);
    chk_l("t4_pmem_wdata", bus.pmem_wdata, wd2);
    bus.pmem_resp = 1'b1;
    tick;
    bus.pmem_resp = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    chk("t4_d_resp", bus.d_resp, 1'b1);
    chk("t4_pmem_write_off", bus.pmem_write, 1'b0);
    tick;
    chk("t4_d_resp_once", bus.d_resp, 1'b0);

    // Error forwarding, then a clean read clears it
    bus.i_read = 1'b1; bus.i_address = 32'h0000_0700;
    tick;
    bus.pmem_resp = 1'b1; bus.pmem_error = 1'b1; bus.pmem_rdata = rd_e;
    tick;
    bus.pmem_resp = 1'b0; bus.pmem_error = 1'b0; bus.i_read = 1'b0;
    chk("t5_i_resp", bus.i_resp, 1'b1);
    chk("t5_i_error", bus.i_error, 1'b1);
    chk("t5_d_error", bus.d_error, 1'b0);
    tick;
    chk("t5_i_error_off", bus.i_error, 1'b0);
    bus.i_read = 1'b1; bus.i_address = 32'h0000_0720;
    tick;
    bus.pmem_resp = 1'b1;
    tick;
    bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
    chk("t5_clean_resp", bus.i_resp, 1'b1);
    chk("t5_clean_error", bus.i_error, 1'b0);
    tick;

    // Reset during BUSY aborts; the held request is re-granted afterwards
    bus.i_read = 1'b1; bus.i_address = 32'h0000_0844;
    tick;
    chk("t6_pmem_read", bus.pmem_read, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_drop", bus.pmem_read, 1'b0);
    chk_a("t6_async_address", bus.pmem_address, 32'h0);
    bus.pmem_resp = 1'b1;
    tick;
    chk("t6_no_resp_a", bus.i_resp, 1'b0);
    tick;
    chk("t6_no_resp_b", bus.i_resp, 1'b0);
    bus.pmem_resp = 1'b0;
    rst_n = 1'b1;
    tick;
    chk("t6_regrant", bus.pmem_read, 1'b1);
    chk_a("t6_regrant_address", bus.pmem_address, 32'h0000_0840);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = rd_f;
    tick;
    bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
    chk("t6_i_resp", bus.i_resp, 1'b1);
    chk_l("t6_i_rdata", bus.i_rdata, rd_f);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
